// File: rtl/alu_sequencer.sv
// Instruction sequencer: program buffer + PC, issues words to the ALU datapath over Start/Rdy.
// Optional watchdog compiled in with `define SEQ_WATCHDOG_EN (TIMEOUT EXEC cycles per instruction).
module alu_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [15:0]   LoadData,
    input  logic          Run,
    input  logic          Abort,
    output logic [15:0]   Instr,
    output logic          Start,
    input  logic          Rdy,
    output logic [AW-1:0] Pc,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [AW-1:0] LastPc = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   instr_q, instr_d;
    logic          start_q, busy_q, done_q;
    logic          wd_hit;
    logic [15:0]   mem_q [DEPTH];

    // Buffer is deliberately not reset so a program survives RST.
    always_ff @(posedge CLK) begin
        if (LoadEn && !busy_q) begin
            mem_q[LoadAddr] <= LoadData;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);
    logic [7:0] wd_q, wd_d;
    logic       err_q;

    // Held at zero outside EXEC, so it always enters EXEC cleared.
    always_comb begin
        wd_d = wd_q;
        if (state_q != S_EXEC) begin
            wd_d = 8'd0;
        end else if (!Rdy) begin
            wd_d = wd_q + 8'd1;
        end
    end

    assign wd_hit = (state_q == S_EXEC) && !Rdy && (wd_q == WdLast);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wd_q  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= (state_d == S_ERR);
        end
    end

    assign Err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign wd_hit         = 1'b0;
    assign Err            = 1'b0;
`endif

    // Handshake: Start is held high for the whole EXEC state with Instr stable; the
    // datapath raises Rdy for a cycle when done, and Rdy is only looked at in EXEC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Run) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                    end
                end
                S_FETCH: begin
                    instr_d = mem_q[pc_q];
                    state_d = (mem_q[pc_q][15:12] == 4'hF) ? S_DONE : S_EXEC;
                end
                S_EXEC: begin
                    if (Rdy) begin
                        if (pc_q == LastPc) begin
                            state_d = S_DONE;
                        end else begin
                            pc_d    = pc_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end else if (wd_hit) begin
                        state_d = S_ERR;
                    end
                end
                S_DONE, S_ERR: begin
                    if (Run) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                    end else if (state_q == S_DONE) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state to keep input-to-output paths out.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= 16'h0000;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            start_q <= (state_d == S_EXEC);
            busy_q  <= (state_d == S_FETCH) || (state_d == S_EXEC);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign Instr       = instr_q;
    assign Start       = start_q;
    assign Pc          = pc_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: table-driven programs with an Instr scoreboard plus hand-written corner sequences.
module tb_alu_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          LoadEn, Run, Abort, Rdy;
  logic [AW-1:0] LoadAddr;
  logic [15:0]   LoadData, Instr;
  logic          Start, Busy, Done, Err;
  logic [AW-1:0] Pc;
  logic [2:0]    dbg_state;

  alu_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .Run(Run), .Abort(Abort), .Instr(Instr), .Start(Start), .Rdy(Rdy), .Pc(Pc),
    .Busy(Busy), .Done(Done), .Err(Err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] head;
    logic [15:0] fill;
    int          delay;
    int          exp_issues;
    int          exp_pc;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] exp_q[$];
  logic [15:0] prog_m[DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic load_word(input int i, input logic [15:0] w);
    @(negedge CLK);
    LoadEn = 1'b1; LoadAddr = AW'(i); LoadData = w;
    @(negedge CLK);
    LoadEn = 1'b0;
    prog_m[i] = w;
  endtask

  task automatic load_vec(input vec_t v);
    logic [15:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = (i < 4) ? v.head[63 - 16*i -: 16] : v.fill + 16'(i);
      load_word(i, w);
    end
  endtask

  task automatic pulse_run();
    @(negedge CLK); Run = 1'b1;
    @(negedge CLK); Run = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int delay, input int exp_issues,
                               input int exp_pc, input bit ld0, input logic [15:0] ld_word);
    int issues = 0, busy_cnt = 0, done_cnt = 0, wait_cnt = 0, cyc = 0, model_busy;
    bit prev_start = 1'b0, halted = 1'b0;
    logic [15:0] got;
    @(negedge CLK);
    if (ld0) begin
      LoadEn = 1'b1; LoadAddr = '0; LoadData = ld_word; prog_m[0] = ld_word;
    end
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (prog_m[i][15:12] == 4'hF) begin
        halted = 1'b1;
        break;
      end
      exp_q.push_back(prog_m[i]);
    end
    model_busy = exp_q.size() * (delay + 2) + (halted ? 1 : 0);
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0; LoadEn = 1'b0;
    while (cyc < 1000) begin
      if (Busy) busy_cnt++;
      if (Start && !prev_start) begin
        issues++;
        wait_cnt = 0;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL %s issue: unexpected issue of 0x%0h, expected none", tag, Instr);
        end else begin
          got = exp_q.pop_front();
          check({tag, " instr"}, 32'(Instr), 32'(got));
        end
      end
      if (Start) begin
        Rdy = (wait_cnt == delay);
        wait_cnt++;
      end else begin
        Rdy = 1'b0;
      end
      prev_start = Start;
      if (Done) begin
        done_cnt++;
        check({tag, " start at done"}, 32'(Start), 0);
        break;
      end
      cyc++;
      @(negedge CLK);
    end
    Rdy = 1'b0;
    check({tag, " done seen"}, done_cnt, 1);
    check({tag, " issues"}, issues, exp_issues);
    check({tag, " pc"}, 32'(Pc), exp_pc);
    check({tag, " busy cycles"}, busy_cnt, model_busy);
    check({tag, " queue left"}, exp_q.size(), 0);
    check({tag, " err"}, 32'(Err), 0);
    @(negedge CLK);
    check({tag, " done pulse width"}, 32'(Done), 0);
    check({tag, " idle after"}, 32'(Busy), 0);
  endtask

  initial begin
    int k, cnt;
    RST = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    Run = 1'b0; Abort = 1'b0; Rdy = 1'b0;

    vecs[0] = '{64'h5001_61F2_4001_F000, 16'h1000, 0, 3, 3};
    vecs[1] = '{64'h1111_2222_3333_4444, 16'h7000, 0, 16, 15};
    vecs[2] = '{64'hF123_0000_0000_0000, 16'h0000, 0, 0, 0};
    vecs[3] = '{64'h0ABC_1234_E000_FFFF, 16'h0000, 3, 3, 3};
    vecs[4] = '{64'h9000_8001_7002_6003, 16'h2100, 2, 16, 15};
    vecs[5] = '{64'hAAAA_F5F5_0001_0002, 16'h3000, 1, 1, 1};

    #2;
    check("reset instr", 32'(Instr), 0);
    check("reset start", 32'(Start), 0);
    check("reset pc", 32'(Pc), 0);
    check("reset busy", 32'(Busy), 0);
    check("reset done", 32'(Done), 0);
    check("reset err", 32'(Err), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post reset state", 32'(dbg_state), 0);

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      run_and_check($sformatf("vec%0d", v), vecs[v].delay, vecs[v].exp_issues, vecs[v].exp_pc, 1'b0, 16'h0);
    end

    // HALT in slot 0: one FETCH cycle, then Done
    load_word(0, 16'hF123);
    pulse_run();
    check("halt fetch busy", 32'(Busy), 1);
    check("halt fetch start", 32'(Start), 0);
    check("halt fetch done", 32'(Done), 0);
    @(negedge CLK);
    check("halt done", 32'(Done), 1);
    check("halt busy off", 32'(Busy), 0);
    check("halt start", 32'(Start), 0);
    check("halt instr", 32'(Instr), 32'h0000F123);
    @(negedge CLK);
    check("halt done drop", 32'(Done), 0);

    // Abort in EXEC, with ignored load and run while busy
    load_vec(vecs[1]);
    pulse_run();
    @(negedge CLK);
    check("abort exec start", 32'(Start), 1);
    check("abort exec instr", 32'(Instr), 32'(prog_m[0]));
    LoadEn = 1'b1; LoadAddr = '0; LoadData = 16'hDEAD; Run = 1'b1;
    @(negedge CLK);
    LoadEn = 1'b0; Run = 1'b0;
    check("run while busy start", 32'(Start), 1);
    check("run while busy pc", 32'(Pc), 0);
    Abort = 1'b1; Run = 1'b1;
    @(negedge CLK);
    Abort = 1'b0; Run = 1'b0;
    check("abort start", 32'(Start), 0);
    check("abort busy", 32'(Busy), 0);
    check("abort instr kept", 32'(Instr), 32'(prog_m[0]));
    @(negedge CLK);
    check("abort beats run", 32'(Busy), 0);
    run_and_check("after abort", 0, 16, 15, 1'b0, 16'h0);

    // Load slot 0 and Run on the same edge
    run_and_check("load+run", 1, 16, 15, 1'b1, 16'h3210);

    // Asynchronous reset mid-EXEC
    pulse_run();
    k = 0;
    while (!(Start && Pc == AW'(2)) && k < 20) begin
      Rdy = Start;
      k++;
      @(negedge CLK);
    end
    Rdy = 1'b0;
    check("pre reset pc", 32'(Pc), 2);
    #2 RST = 1'b0;
    #1;
    check("async instr", 32'(Instr), 0);
    check("async start", 32'(Start), 0);
    check("async pc", 32'(Pc), 0);
    check("async busy", 32'(Busy), 0);
    check("async done", 32'(Done), 0);
    check("async err", 32'(Err), 0);
    @(negedge CLK);
    RST = 1'b1;
    run_and_check("rerun after reset", 1, 16, 15, 1'b0, 16'h0);

`ifdef SEQ_WATCHDOG_EN
    pulse_run();
    Rdy = 1'b0; cnt = 0; k = 0;
    while (!Err && k < 50) begin
      if (Start) cnt++;
      k++;
      @(negedge CLK);
    end
    check("wd exec cycles", cnt, 4);
    check("wd err", 32'(Err), 1);
    check("wd start", 32'(Start), 0);
    check("wd busy", 32'(Busy), 0);
    @(negedge CLK);
    check("wd err sticky", 32'(Err), 1);
    pulse_run();
    check("wd run clears err", 32'(Err), 0);
    check("wd run fetch", 32'(Busy), 1);
    Abort = 1'b1;
    @(negedge CLK);
    Abort = 1'b0;
    check("wd abort idle", 32'(Busy), 0);
    run_and_check("wd rdy 4th", 3, 16, 15, 1'b0, 16'h0);
`else
    pulse_run();
    Rdy = 1'b0;
    repeat (60) @(negedge CLK);
    check("no wd err", 32'(Err), 0);
    check("no wd still exec", 32'(Start), 1);
    check("no wd busy", 32'(Busy), 1);
    Abort = 1'b1;
    @(negedge CLK);
    Abort = 1'b0;
    check("no wd abort", 32'(Busy), 0);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
